// File: rtl/residual_update_pkg.sv
// Shared types and defaults for the CG residual update datapath.
// Word count helper assumes 8 lanes per packed memory word.
package residual_update_pkg;

  localparam int LANE_W = 32;
  localparam int FRAC   = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    CALC  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  function automatic logic [31:0] words_of(
    input logic [31:0] total
  );
    return total >> 3;
  endfunction

endpackage

// File: rtl/residual_update_unit_lane_axpy.sv
// One lane: r_new = r - (alpha*ap >>> frac) and (r_new^2 >>> frac).
// Purely combinational; the parent registers the results.
module lane_axpy
  import residual_update_pkg::*;
#(
  parameter int W    = LANE_W,
  parameter int FRAC_B = FRAC
) (
  input  logic [W-1:0] alpha,
  input  logic [W-1:0] r,
  input  logic [W-1:0] ap,
  output logic [W-1:0] r_new,
  output logic [W-1:0] sq
);

  logic signed [2*W-1:0] prod;
  logic signed [2*W-1:0] prod_sq;
  logic        [W-1:0]   shifted;

  always_comb begin
    prod    = $signed(alpha) * $signed(ap);
    shifted = W'(prod >>> FRAC_B);
    r_new   = r - shifted;
    prod_sq = $signed(r_new) * $signed(r_new);
    sq      = W'(prod_sq >>> FRAC_B);
  end

endmodule

// File: rtl/residual_update_unit.sv
// Residual update r -= alpha*ap over a packed R stream,
// writing each word back and accumulating sum(r_new^2).
module residual_update_unit
  import residual_update_pkg::*;
#(
  parameter int no_of_units               = 8,
  parameter int element_width             = LANE_W,
  parameter int frac_bits                 = FRAC,
  parameter int memory_read_address_width = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [31:0]                          total,
  input  logic [element_width-1:0]             alpha,
  input  logic [no_of_units*element_width-1:0] r_in,
  input  logic [no_of_units*element_width-1:0] ap_in,
  input  logic                                 in_valid,
  output logic                                 read_again,
  output logic [no_of_units*element_width-1:0] r_out,
  output logic                                 result_mem_we_5,
  output logic [memory_read_address_width-1:0] result_mem_counter_5,
  output logic [element_width-1:0]             rr_dot,
  output logic                                 finish_alu,
  output logic                                 busy
);

  localparam int W  = element_width;
  localparam int N  = no_of_units;
  localparam int AW = memory_read_address_width;

  state_t         state_q, state_d;
  logic [W-1:0]   alpha_q, alpha_d;
  logic [AW-1:0]  words_q, words_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [N*W-1:0] r_cap_q, r_cap_d;
  logic [N*W-1:0] ap_cap_q, ap_cap_d;
  logic [N*W-1:0] r_out_q, r_out_d;
  logic [W-1:0]   sq_q, sq_d;
  logic [W-1:0]   rr_q, rr_d;

  logic [N*W-1:0] r_new_w;
  logic [W-1:0]   sq_w [N];
  logic [W-1:0]   sq_sum;
  logic           last;

  for (genvar g = 0; g < N; g++) begin : g_lane
    lane_axpy #(
      .W      (W),
      .FRAC_B (frac_bits)
    ) u_lane (
      .alpha (alpha_q),
      .r     (r_cap_q[g*W +: W]),
      .ap    (ap_cap_q[g*W +: W]),
      .r_new (r_new_w[g*W +: W]),
      .sq    (sq_w[g])
    );
  end

  always_comb begin
    sq_sum = '0;
    for (int i = 0; i < N; i++) begin
      sq_sum = sq_sum + sq_w[i];
    end
  end

  assign last = (idx_q == words_q - AW'(1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      alpha_q  <= '0;
      words_q  <= '0;
      idx_q    <= '0;
      r_cap_q  <= '0;
      ap_cap_q <= '0;
      r_out_q  <= '0;
      sq_q     <= '0;
      rr_q     <= '0;
    end else begin
      state_q  <= state_d;
      alpha_q  <= alpha_d;
      words_q  <= words_d;
      idx_q    <= idx_d;
      r_cap_q  <= r_cap_d;
      ap_cap_q <= ap_cap_d;
      r_out_q  <= r_out_d;
      sq_q     <= sq_d;
      rr_q     <= rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (words_of(total) == 32'd0) ? DONE : REQ;
        end
      end
      REQ:   state_d = WAIT;
      WAIT:  state_d = in_valid ? CALC : WAIT;
      CALC:  state_d = WRITE;
      WRITE: state_d = last ? DONE : REQ;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alpha_d  = alpha_q;
    words_d  = words_q;
    idx_d    = idx_q;
    r_cap_d  = r_cap_q;
    ap_cap_d = ap_cap_q;
    r_out_d  = r_out_q;
    sq_d     = sq_q;
    rr_d     = rr_q;
    unique case (1'b1)
      (state_q == IDLE) && start: begin
        alpha_d = alpha;
        words_d = AW'(words_of(total));
        idx_d   = '0;
        rr_d    = '0;
      end
      (state_q == WAIT) && in_valid: begin
        r_cap_d  = r_in;
        ap_cap_d = ap_in;
      end
      (state_q == CALC): begin
        r_out_d = r_new_w;
        sq_d    = sq_sum;
      end
      (state_q == WRITE): begin
        rr_d = rr_q + sq_q;
        if (!last) idx_d = idx_q + AW'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    read_again      = (state_q == REQ);
    result_mem_we_5 = (state_q == WRITE);
    finish_alu      = (state_q == DONE);
    busy            = (state_q != IDLE);
  end

  assign r_out                = r_out_q;
  assign result_mem_counter_5 = idx_q;
  assign rr_dot               = rr_q;

endmodule

// File: tb/tb_residual_update_unit.sv
// Randomized self-checking bench for residual_update_unit
// against a plain-arithmetic fixed-point reference.
module tb_residual_update_unit;

  logic         clk = 0;
  logic         reset;
  logic         start;
  logic [31:0]  total;
  logic [31:0]  alpha;
  logic [255:0] r_in;
  logic [255:0] ap_in;
  logic         in_valid;
  logic         read_again;
  logic [255:0] r_out;
  logic         we;
  logic [31:0]  cnt;
  logic [31:0]  rr_dot;
  logic         finish_alu;
  logic         busy;

  int total_n = 0;
  int bad_n   = 0;

  logic [31:0] rv [8];
  logic [31:0] av [8];

  always #5 clk = ~clk;

  residual_update_unit dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .total                (total),
    .alpha                (alpha),
    .r_in                 (r_in),
    .ap_in                (ap_in),
    .in_valid             (in_valid),
    .read_again           (read_again),
    .r_out                (r_out),
    .result_mem_we_5      (we),
    .result_mem_counter_5 (cnt),
    .rr_dot               (rr_dot),
    .finish_alu           (finish_alu),
    .busy                 (busy)
  );

  task automatic chk(
    input string       tag,
    input logic [255:0] got,
    input logic [255:0] exp
  );
    total_n++;
    if (got !== exp) begin
      bad_n++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Q16.16 reference: r - alpha*ap/2^16, wrapped to 32 bits
  function automatic logic [31:0] ref_rnew(
    input logic [31:0] r, input logic [31:0] ap,
    input logic [31:0] al
  );
    longint p;
    longint s;
    p = longint'($signed(al)) * longint'($signed(ap));
    s = p >>> 16;
    return r - s[31:0];
  endfunction

  function automatic logic [31:0] ref_sq(input logic [31:0] v);
    longint p;
    longint s;
    p = longint'($signed(v)) * longint'($signed(v));
    s = p >>> 16;
    return s[31:0];
  endfunction

  task automatic fill(input bit rnd, input logic [31:0] r0,
                      input logic [31:0] a0);
    for (int i = 0; i < 8; i++) begin
      rv[i] = rnd ? $urandom : r0;
      av[i] = rnd ? $urandom : a0;
    end
  endtask

  task automatic run_pass(
    input string tag, input int tot, input logic [31:0] al,
    input int dly, input bit poke, input bit rnd,
    input logic [31:0] r0, input logic [31:0] a0
  );
    int          words;
    int          to;
    int          nfin;
    logic [31:0] exp_rr;
    logic [255:0] exp_w;
    words  = tot >> 3;
    exp_rr = '0;
    @(negedge clk);
    start = 1; total = tot; alpha = al;
    @(negedge clk);
    start = 0;
    for (int w = 0; w < words; w++) begin
      to = 0;
      while (!read_again && to < 50) begin
        chk({tag, ":we_idle"}, we, 1'b0);
        @(negedge clk);
        to++;
      end
      chk({tag, ":req"}, read_again, 1'b1);
      if (!read_again) return;
      @(negedge clk);
      chk({tag, ":req_1cyc"}, read_again, 1'b0);
      for (int d = 0; d < dly; d++) begin
        chk({tag, ":wait_no_we"}, we, 1'b0);
        @(negedge clk);
      end
      fill(rnd, r0, a0);
      for (int i = 0; i < 8; i++) begin
        r_in[i*32 +: 32]  = rv[i];
        ap_in[i*32 +: 32] = av[i];
        exp_w[i*32 +: 32] = ref_rnew(rv[i], av[i], al);
        exp_rr = exp_rr + ref_sq(exp_w[i*32 +: 32]);
      end
      in_valid = 1;
      @(negedge clk);
      in_valid = 0;
      r_in = $urandom; ap_in = $urandom;
      chk({tag, ":calc_no_we"}, we, 1'b0);
      if (poke) start = 1;
      @(negedge clk);
      start = 0;
      chk({tag, ":we"}, we, 1'b1);
      chk({tag, ":cnt"}, cnt, 32'(w));
      chk({tag, ":r_out"}, r_out, exp_w);
      @(negedge clk);
    end
    chk({tag, ":finish"}, finish_alu, 1'b1);
    chk({tag, ":fin_no_req"}, read_again, 1'b0);
    nfin = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      nfin += int'(finish_alu);
      if (read_again) nfin += 10;
    end
    chk({tag, ":single_fin"}, 32'(nfin), 32'd0);
    chk({tag, ":idle"}, busy, 1'b0);
    chk({tag, ":rr_dot"}, rr_dot, exp_rr);
  endtask

  initial begin
    reset = 0; start = 0; total = 0; alpha = 0;
    r_in = 0; ap_in = 0; in_valid = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rr", rr_dot, 32'd0);
    chk("rst_rout", r_out, 256'd0);
    chk("rst_cnt", cnt, 32'd0);
    chk("rst_ctl", {read_again, we, finish_alu}, 3'b000);
    reset = 1;
    @(negedge clk);
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    chk("stray_valid", busy, 1'b0);

    run_pass("s1", 16, 32'h0001_0000, 0, 0, 0,
             32'h0005_0000, 32'h0002_0000);
    chk("s1_rr144", rr_dot, 32'h0090_0000);
    chk("s1_lane", r_out[31:0], 32'h0003_0000);
    run_pass("s2", 8, 32'hFFFF_8000, 0, 0, 0,
             32'h0, 32'h0004_0000);
    chk("s2_lane", r_out[255:224], 32'h0002_0000);
    run_pass("s3", 7, 32'h0001_0000, 0, 0, 0, 0, 0);
    run_pass("s4", 16, 32'h0001_0000, 5, 0, 0,
             32'h0005_0000, 32'h0002_0000);
    chk("s4_rr144", rr_dot, 32'h0090_0000);

    // abort mid-pass while waiting for data
    @(negedge clk);
    start = 1; total = 24; alpha = 32'h0001_0000;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    chk("abort_busy_pre", busy, 1'b1);
    reset = 0;
    @(negedge clk);
    reset = 1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_out", {r_out, cnt, rr_dot}, '0);
    chk("abort_ctl", {read_again, we, finish_alu}, 3'b000);
    run_pass("s5", 24, 32'h0000_8000, 1, 0, 1, 0, 0);

    run_pass("s6", 24, 32'h0002_0000, 0, 1, 1, 0, 0);

    for (int t = 0; t < 6; t++) begin
      run_pass("rnd", int'($urandom_range(0, 40)), $urandom,
               int'($urandom_range(0, 3)), t[0], 1, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
